// File: rtl/cnt_slice_arb_if.sv
// Bundle between the cnt_slice_arb sequencer, its timing clients and the shared slice counter.
// The slave modport is the arbiter's view; master is the client/counter side.
interface cnt_slice_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dur;
    logic                  hold;
    logic                  cnt_co;
    logic [WIDTH-1:0]      cnt_d;
    logic                  cnt_load;
    logic                  cnt_sp;
    logic                  cnt_ci;
    logic                  cnt_clr;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (
        output req, dur, hold, cnt_co,
        input  cnt_d, cnt_load, cnt_sp, cnt_ci, cnt_clr, gnt, done, busy
    );

    modport slave (
        input  req, dur, hold, cnt_co,
        output cnt_d, cnt_load, cnt_sp, cnt_ci, cnt_clr, gnt, done, busy
    );
endinterface

// File: rtl/cnt_slice_arb.sv
// Round-robin arbiter/sequencer time-sharing one cascaded slice counter among NREQ requesters.
// Define CNT_SLICE_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cnt_slice_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input logic           ck,
    input logic           rst,
    cnt_slice_arb_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StInit, StIdle, StLoad, StRun, StFin, StAbort} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   g_q, g_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win;
    logic              win_vld;
    logic [WIDTH-1:0]  dur_win;
    logic              req_g;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  cnt_d_q, cnt_d_d;
    logic              load_q, load_d;
    logic              sp_q, sp_d;
    logic              clr_q, clr_d;
    logic              busy_q, busy_d;

    // Winner search starts at the pointer and wraps; the pointer stays 0 in priority mode.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand    = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NREQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        dur_win = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IdxW'(i)) begin
                dur_win = bus.dur[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_g = bus.req[g_q];

    // State register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  state_d = StIdle;
            StIdle:  if (win_vld) state_d = StLoad;
            StLoad:  state_d = req_g ? StRun : StAbort;
            StRun: begin
                // Terminal carry beats a simultaneous request drop.
                if (bus.cnt_co) begin
                    state_d = StFin;
                end else if (!req_g) begin
                    state_d = StAbort;
                end
            end
            StFin:   state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        g_d = g_q;
        if (state_q == StIdle && win_vld) begin
            g_d = win;
        end
`ifdef CNT_SLICE_ARB_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = ptr_q;
        if (state_q == StFin || state_q == StAbort) begin
            ptr_d = (g_q == IdxW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        end
`endif
    end

    // Output logic: decode the upcoming state so every control line leaves a flop.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        load_d  = 1'b0;
        sp_d    = 1'b0;
        clr_d   = 1'b0;
        busy_d  = 1'b1;
        cnt_d_d = cnt_d_q;
        case (state_d)
            StInit: clr_d = 1'b1;
            StIdle: begin
                busy_d  = 1'b0;
                cnt_d_d = '0;
            end
            StLoad: begin
                gnt_d  = NREQ'(1) << g_d;
                load_d = 1'b1;
                sp_d   = 1'b1;
                if (state_q == StIdle) begin
                    // Loading the complement makes the counter wrap after DUR+1 enabled counts.
                    cnt_d_d = ~dur_win;
                end
            end
            StRun: begin
                gnt_d = NREQ'(1) << g_d;
                sp_d  = 1'b1;
            end
            StFin: begin
                gnt_d  = NREQ'(1) << g_d;
                done_d = NREQ'(1) << g_d;
                clr_d  = 1'b1;
            end
            StAbort: clr_d = 1'b1;
            default: clr_d = 1'b1;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_d_q <= '0;
            load_q  <= 1'b0;
            sp_q    <= 1'b0;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_d_q <= cnt_d_d;
            load_q  <= load_d;
            sp_q    <= sp_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.cnt_d    = cnt_d_q;
    assign bus.cnt_load = load_q;
    assign bus.cnt_sp   = sp_q;
    assign bus.cnt_clr  = clr_q;
    assign bus.busy     = busy_q;
    assign bus.cnt_ci   = (state_q == StRun) && !bus.hold;

endmodule

// File: tb/tb_cnt_slice_arb.sv
// Scoreboard bench for cnt_slice_arb with a behavioural model of the cascaded slice counter.
// Expectations follow CNT_SLICE_ARB_PRIO_EN when it is defined.
module tb_cnt_slice_arb;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] d;
    } load_t;

    typedef struct {
        logic [NREQ-1:0] vec;
        int              cyc;
        int              run;
    } done_t;

    logic ck;
    logic rst;
    int   cyc = 0;
    int   run_len = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    load_t load_q[$];
    done_t done_q[$];
    logic [WIDTH-1:0] cnt_m;

    cnt_slice_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    cnt_slice_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    always @(posedge ck) cyc <= cyc + 1;

    // Slice chain model: sync clear, load when enabled, otherwise count on carry-in.
    always @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt_m <= '0;
        end else if (bus.cnt_clr) begin
            cnt_m <= '0;
        end else if (bus.cnt_sp) begin
            if (bus.cnt_load) cnt_m <= bus.cnt_d;
            else if (bus.cnt_ci) cnt_m <= cnt_m + 1'b1;
        end
    end
    assign bus.cnt_co = (&cnt_m) && bus.cnt_ci;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge ck) begin
        if (!rst) begin
            if (bus.cnt_load) begin
                run_len <= 0;
                if (load_q.size() == 0) begin
                    check("load_unexpected", 32'(bus.cnt_load), 0);
                end else begin
                    check("load_gnt", 32'(bus.gnt), 32'(load_q[0].gnt));
                    check("load_cnt_d", 32'(bus.cnt_d), 32'(load_q[0].d));
                    load_q.delete(0);
                end
            end else if (bus.cnt_sp) begin
                run_len <= run_len + 1;
            end
            if (bus.done != '0) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 0);
                end else begin
                    check("done_vec", 32'(bus.done), 32'(done_q[0].vec));
                    check("done_cycle", cyc, done_q[0].cyc);
                    check("run_len", run_len, done_q[0].run);
                    done_q.delete(0);
                end
            end
        end
    end

    // Called in an IDLE cycle t: LOAD at t+1, DONE at t+3+DUR plus any HOLD cycles.
    task automatic start_req(input int idx, input logic [WIDTH-1:0] d, input int holds,
                             input bit want_done);
        logic [NREQ-1:0] v;
        v = NREQ'(1) << idx;
        bus.dur[idx*WIDTH +: WIDTH] = d;
        bus.req[idx] = 1'b1;
        load_q.push_back(load_t'{v, ~d});
        if (want_done) done_q.push_back(done_t'{v, cyc + 3 + int'(d) + holds, int'(d) + 1 + holds});
    endtask

    task automatic wait_done(input int idx, input int budget, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge ck);
            if (bus.done[idx]) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        if (drop) bus.req[idx] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_cnt_d"}, 32'(bus.cnt_d), 0);
        check({tag, "_load"}, 32'(bus.cnt_load), 0);
        check({tag, "_sp"}, 32'(bus.cnt_sp), 0);
        check({tag, "_ci"}, 32'(bus.cnt_ci), 0);
        check({tag, "_clr"}, 32'(bus.cnt_clr), 1);
        check({tag, "_busy"}, 32'(bus.busy), 1);
    endtask

    initial begin
        int t;
        logic [NREQ-1:0] v;
        rst = 1'b1;
        bus.req  = '0;
        bus.dur  = '0;
        bus.hold = 1'b0;
        repeat (2) @(negedge ck);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("init_clr", 32'(bus.cnt_clr), 1);
        @(negedge ck);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_clr", 32'(bus.cnt_clr), 0);
        check("idle_gnt", 32'(bus.gnt), 0);

        // Single request, DUR=5
        start_req(1, 16'd5, 0, 1'b1);
        wait_done(1, 40, 1'b1);
        @(negedge ck);

        // Same request with HOLD high for three RUN cycles
        start_req(1, 16'd5, 3, 1'b1);
        repeat (2) @(negedge ck);
        check("ci_run", 32'(bus.cnt_ci), 1);
        bus.hold = 1'b1;
        #1;
        check("ci_hold", 32'(bus.cnt_ci), 0);
        repeat (3) @(negedge ck);
        bus.hold = 1'b0;
        wait_done(1, 40, 1'b1);
        @(negedge ck);

        // Terminal carry and request drop in the same cycle: completion wins
        start_req(1, 16'd3, 0, 1'b1);
        repeat (5) @(negedge ck);
        check("co_last_run", 32'(bus.cnt_co), 1);
        bus.req[1] = 1'b0;
        wait_done(1, 10, 1'b1);
        @(negedge ck);

        // Abort: requester 2 drops in its third RUN cycle; 0 and 3 wait meanwhile
        start_req(2, 16'd10, 0, 1'b0);
        @(negedge ck);
        bus.dur[0 +: WIDTH]       = 16'd0;
        bus.dur[3*WIDTH +: WIDTH] = 16'd1;
        bus.req[0] = 1'b1;
        bus.req[3] = 1'b1;
        repeat (3) @(negedge ck);
        bus.req[2] = 1'b0;
        @(negedge ck);
        check("abort_clr", 32'(bus.cnt_clr), 1);
        check("abort_done", 32'(bus.done), 0);
        check("abort_busy", 32'(bus.busy), 1);
        t = cyc + 1;
`ifdef CNT_SLICE_ARB_PRIO_EN
        load_q.push_back(load_t'{4'b0001, 16'hFFFF});
        done_q.push_back(done_t'{4'b0001, t + 3, 1});
        load_q.push_back(load_t'{4'b1000, 16'hFFFE});
        done_q.push_back(done_t'{4'b1000, t + 8, 2});
        wait_done(0, 20, 1'b1);
        wait_done(3, 20, 1'b1);
`else
        load_q.push_back(load_t'{4'b1000, 16'hFFFE});
        done_q.push_back(done_t'{4'b1000, t + 4, 2});
        load_q.push_back(load_t'{4'b0001, 16'hFFFF});
        done_q.push_back(done_t'{4'b0001, t + 8, 1});
        wait_done(3, 20, 1'b1);
        wait_done(0, 20, 1'b1);
`endif
        @(negedge ck);

        // Reset pulsed mid-RUN with requester 2 granted
        start_req(2, 16'd20, 0, 1'b0);
        repeat (4) @(negedge ck);
        check("pre_rst_gnt", 32'(bus.gnt), 32'h4);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        bus.req[2] = 1'b0;
        @(negedge ck);
        rst = 1'b0;
        #1;
        check("post_rst_init_clr", 32'(bus.cnt_clr), 1);
        @(negedge ck);
        check("post_rst_busy", 32'(bus.busy), 0);

        // All four requesting with DUR=2: rotation, one DONE every 6 cycles
        t = cyc;
        bus.dur = {4{16'd2}};
        bus.req = '1;
        for (int k = 0; k < 5; k++) begin
`ifdef CNT_SLICE_ARB_PRIO_EN
            v = 4'b0001;
`else
            v = NREQ'(1) << (k % NREQ);
`endif
            load_q.push_back(load_t'{v, 16'hFFFD});
            done_q.push_back(done_t'{v, t + 5 + 6 * k, 3});
        end
        for (int k = 0; k < 5; k++) begin
`ifdef CNT_SLICE_ARB_PRIO_EN
            wait_done(0, 20, 1'b0);
`else
            wait_done(k % NREQ, 20, 1'b0);
`endif
        end
        bus.req = '0;
        @(negedge ck);

        // Longest practical delay: counter loads 0x0001
        start_req(0, 16'hFFFE, 0, 1'b1);
        wait_done(0, 70000, 1'b1);
        @(negedge ck);
        check("idle_end_busy", 32'(bus.busy), 0);

        check("load_q_left", load_q.size(), 0);
        check("done_q_left", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cnt_slice_arb.md
# cnt_slice_arb

Round-robin arbiter and sequencer that time-shares one cascaded loadable up-counter (a chain of 4-bit slices with carry-in/carry-out) among NREQ requesters.
- Each requester asks for a delay of DUR clock cycles. The block grants the counter, loads it, runs it until terminal carry, and pulses a per-requester DONE.
- It sits between timing clients and the shared counter datapath, and owns every counter control line.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, counter width in bits; must be a multiple of 4 (one slice per 4 bits)
- CK  input  1  clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-high
- REQ  input  NREQ  per-requester request level; held until DONE or deliberately dropped (abort)
- DUR  input  NREQ*WIDTH  packed delay per requester; requester i uses bits [i*WIDTH +: WIDTH]
- HOLD  input  1  pause counting while high
- CNT_CO  input  1  terminal carry-out of the last counter slice
- CNT_D  output  WIDTH  load data to the slices
- CNT_LOAD  output  1  load select (1 = load CNT_D, 0 = count)
- CNT_SP  output  1  counter clock enable
- CNT_CI  output  1  carry-in to the first slice
- CNT_CLR  output  1  synchronous clear to the slices
- GNT  output  NREQ  one-hot grant; all zero when idle
- DONE  output  NREQ  one-cycle completion pulse to the granted requester
- BUSY  output  1  high in any state except IDLE

## Operation
- States:
  - INIT: after reset, one cycle, CNT_CLR=1, then IDLE.
  - IDLE
  - LOAD
  - RUN
  - FIN
  - ABORT
- Reset values: GNT=0, DONE=0, CNT_D=0, CNT_LOAD=0, CNT_SP=0, CNT_CI=0, BUSY=1 (INIT), CNT_CLR=1, round-robin pointer=0.
- IDLE:
  - Any REQ bit set → select a winner g, searching from pointer upward with wrap.
  - Register GNT=1<<g and CNT_D=~DUR[g], then go to LOAD.
  - No REQ → stay in IDLE; all outputs 0.
- LOAD, one cycle: CNT_LOAD=1, CNT_SP=1, CNT_CI=0. The counter takes 2^WIDTH-1-DUR. Next state is RUN.
- RUN:
  - CNT_SP=1 and CNT_LOAD=0.
  - CNT_CI is combinational: ~HOLD.
  - CNT_CO=1 sampled → FIN.
- FIN, one cycle: DONE[g]=1, CNT_CLR=1, GNT held. Pointer becomes g+1 mod NREQ. Next state is IDLE, and GNT clears.
- ABORT:
  - Entered when REQ[g]=0 is sampled in LOAD or RUN.
  - One cycle: CNT_CLR=1, no DONE. Pointer becomes g+1. Next state is IDLE.
- Simultaneous events:
  - In RUN, CO and REQ[g] drop in the same cycle → FIN (completion wins).
- Non-granted requests:
  - Changes to non-granted REQ/DUR bits are ignored outside IDLE.
  - DUR[g] is sampled only on the IDLE→LOAD edge.
- DUR=0: the counter loads all-ones, so CO is seen in the first RUN cycle (with CNT_CI=1).

## Timing
- REQ sampled in IDLE cycle t. Then:
  - LOAD in t+1
  - RUN in t+2 .. t+2+DUR
  - FIN, with DONE, in t+3+DUR
  - IDLE in t+4+DUR
- Each HOLD-high cycle in RUN extends RUN by one cycle.
- Back-to-back grants: the minimum gap between successive LOADs is DUR+4 cycles.
- Registered outputs: GNT, DONE, CNT_D, CNT_LOAD, CNT_SP, CNT_CLR, BUSY.
- Combinational output: only CNT_CI (state decode AND ~HOLD).
- RST asserted mid-operation:
  - All outputs take their reset values immediately; any pending DONE is lost.
  - After deassertion the block restarts in INIT.

## Configuration
- CNT_SLICE_ARB_PRIO_EN:
  - Defined: fixed priority; the lowest-index active REQ always wins, and the pointer is unused (held 0).
  - Undefined: round-robin as described above.

## Test plan
- Test 1, single request and HOLD (bench models the slice counter):
  - REQ[1]=1 with DUR=5 → GNT=0010, CNT_D=0xFFFA at LOAD, RUN lasts 6 cycles, DONE[1] pulses exactly 8 cycles after the IDLE sample.
  - Repeat with HOLD high for 3 RUN cycles → DONE 3 cycles later.
- Round-robin: REQ=1111 held, DUR=2 for all → grants in order 0,1,2,3,0, each DONE spaced 6 cycles.
  - With CNT_SLICE_ARB_PRIO_EN defined, grant 0 repeats.
- Abort: REQ[2] dropped in the 3rd RUN cycle → ABORT with CNT_CLR=1 for one cycle, DONE never asserts, next grant goes to index 3 when it is pending.
- Boundaries:
  - DUR=0 → CO in the first RUN cycle, DONE at t+3.
  - DUR=0xFFFE → counter loads 0x0001, DONE at t+3+0xFFFE.
  - CO and REQ drop in the same cycle → DONE asserted.
- Reset mid-RUN: RST pulsed while in RUN with GNT=0100 → all outputs at reset values within the same cycle, INIT asserts CNT_CLR, then IDLE with pointer 0.
